// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM bus arbiter: access-slot states and grant codes.
package vram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VID_ISSUE = 3'd1,
    VID_DONE  = 3'd2,
    CPU_ISSUE = 3'd3,
    CPU_DONE  = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_e;

  // States in which a new slot may be granted; the ISSUE states always run to DONE.
  function automatic logic is_arb_slot(input arb_state_e s);
    return (s == IDLE) || (s == VID_DONE) || (s == CPU_DONE);
  endfunction

endpackage

// File: rtl/vram_arb_select.sv
// Grant decision for the next VRAM slot plus the CPU starvation counter.
module vram_arb_select
  import vram_arb_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  arb_state_e state,
  input  logic       vid_req,
  input  logic       cpu_req,
  output gnt_e       gnt
);

  localparam int SCW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [SCW-1:0] STALL_CAP = SCW'(MAX_STALL);

  logic [SCW-1:0] stall_cnt;
  logic           cpu_live;
  logic           stall_hit;

  // The counter saturates at the cap, so equality is the ">= cap" test.
  always_comb begin
    gnt       = GNT_NONE;
    cpu_live  = cpu_req && (state != CPU_DONE);
    stall_hit = (stall_cnt == STALL_CAP);
    if (is_arb_slot(state)) begin
      if (cpu_live && (!vid_req || stall_hit)) gnt = GNT_CPU;
      else if (vid_req)                        gnt = GNT_VID;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              stall_cnt <= '0;
    else if (!cpu_req || gnt == GNT_CPU)    stall_cnt <= '0;
    else if (gnt == GNT_VID && !stall_hit)  stall_cnt <= stall_cnt + SCW'(1);
  end

endmodule

// File: rtl/vram_bus_arbiter.sv
// Single-port VRAM shared between the CPU and video fetcher in two-cycle ISSUE/DONE slots.
// Read data is bypassed from the RAM in the DONE cycle and held in a register afterwards.
module vram_bus_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW        = 15,
  parameter int DW        = 8,
  parameter int MAX_STALL = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_rdy,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  arb_state_e    state, state_nxt;
  gnt_e          gnt;
  logic          cpu_rd_q;
  logic [DW-1:0] vid_data_q;
  logic [DW-1:0] cpu_rdata_q;

  vram_arb_select #(.MAX_STALL(MAX_STALL)) u_sel (
    .clk     (clk),
    .reset   (reset),
    .state   (state),
    .vid_req (vid_req),
    .cpu_req (cpu_req),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_addr  = vid_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    case (state)
      VID_ISSUE: state_nxt = VID_DONE;
      CPU_ISSUE: begin
        state_nxt = CPU_DONE;
        ram_addr  = cpu_addr;
        ram_we    = cpu_we;
      end
      default: begin
        case (gnt)
          GNT_VID: state_nxt = VID_ISSUE;
          GNT_CPU: state_nxt = CPU_ISSUE;
          default: state_nxt = IDLE;
        endcase
      end
    endcase
    // Reset kills the strobe immediately, not at the next edge.
    if (reset) begin
      ram_addr = '0;
      ram_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rd_q    <= 1'b0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      if (state == CPU_ISSUE)             cpu_rd_q    <= ~cpu_we;
      if (state == VID_DONE)              vid_data_q  <= ram_rdata;
      if (state == CPU_DONE && cpu_rd_q)  cpu_rdata_q <= ram_rdata;
    end
  end

  assign vid_ack   = (state == VID_DONE);
  assign vid_data  = (state == VID_DONE) ? ram_rdata : vid_data_q;
  assign cpu_rdata = (state == CPU_DONE && cpu_rd_q) ? ram_rdata : cpu_rdata_q;
  assign cpu_rdy   = ~cpu_req | (state == CPU_DONE);

endmodule
